// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (a - b - bin) with a start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf_o.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf_o,
`endif
  output logic             bout_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             dBit, nBorrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic             ovf_q, ovf_d;
`endif

  // One-bit full-subtractor cell on the current LSBs and the carried borrow
  always_comb begin
    dBit    = sa_q[0] ^ sb_q[0] ^ br_q;
    nBorrow = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    aMsb_d  = aMsb_q;
    bMsb_d  = bMsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sa_d    = a_i;
          sb_d    = b_i;
          br_d    = bin_i;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          aMsb_d  = a_i[WIDTH-1];
          bMsb_d  = b_i[WIDTH-1];
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        res_d = {dBit, res_q[WIDTH-1:1]};
        br_d  = nBorrow;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Result, borrow and done all become visible on the same edge
        diff_d  = res_q;
        bout_d  = br_q;
        done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = (aMsb_q ^ bMsb_q) & (res_q[WIDTH-1] ^ aMsb_q);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      aMsb_q  <= aMsb_d;
      bMsb_q  <= bMsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == SHIFT);
  assign done_o  = done_q;
  assign diff_o  = diff_q;
  assign bout_o  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors push expected
// results into a queue, a monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } expect_t;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             bin_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] diff_o;
  logic             bout_o;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_o;
`endif

  expect_t sbQueue[$];
  int      vectors    = 0;
  int      miscompares = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .bin_i   (bin_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .diff_o  (diff_o),
`ifdef SERIAL_SUB_OVF_EN
    .ovf_o   (ovf_o),
`endif
    .bout_o  (bout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sbQueue.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done with diff=%0h, expected no result", diff_o);
      end else begin
        expect_t e;
        e = sbQueue.pop_front();
        checkOutput("sb_diff", 32'(diff_o), 32'(e.diff));
        checkOutput("sb_bout", 32'(bout_o), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("sb_ovf", 32'(ovf_o), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!ready_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready_o) checkOutput("ready_timeout", 32'(ready_o), 32'd1);
  endtask

  // Issues one operation; if extraCycle>0 a second start with FF/00 is pulsed
  // that many cycles after acceptance and must be ignored.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic bin, input logic [WIDTH-1:0] expDiff,
                               input logic expBout, input logic expOvf,
                               input int extraCycle);
    int  lat;
    logic seen;
    expect_t e;
    waitReady();
    @(negedge clk);
    a_i = a; b_i = b; bin_i = bin; start_i = 1'b1;
    e.diff = expDiff; e.bout = expBout; e.ovf = expOvf;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i = '0; b_i = '0; bin_i = 1'b0;
    checkOutput("busy_after_start", 32'(busy_o), 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (extraCycle > 0 && lat == extraCycle) begin
        a_i = 8'hFF; b_i = 8'h00; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    checkOutput("done_latency", 32'(lat), 32'(WIDTH + 1));
    @(posedge clk);
    #1;
    checkOutput("ready_after_done", 32'(ready_o), 32'd1);
    checkOutput("done_single_pulse", 32'(done_o), 32'd0);
    checkOutput("diff_held", 32'(diff_o), 32'(expDiff));
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
    #12;
    checkOutput("rst_ready", 32'(ready_o), 32'd1);
    checkOutput("rst_busy",  32'(busy_o),  32'd0);
    checkOutput("rst_done",  32'(done_o),  32'd0);
    checkOutput("rst_diff",  32'(diff_o),  32'd0);
    checkOutput("rst_bout",  32'(bout_o),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 0);
    applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
    applyStimulus(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 3);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    applyStimulus(8'hA0, 8'h0F, 1'b1, 8'h90, 1'b0, 1'b0, 0);

    // Abort mid-operation: no expectation is queued for the aborted operation
    waitReady();
    @(negedge clk);
    a_i = 8'h77; b_i = 8'h11; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("busy_before_abort", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(ready_o), 32'd1);
    checkOutput("abort_busy",  32'(busy_o),  32'd0);
    checkOutput("abort_diff",  32'(diff_o),  32'd0);
    checkOutput("abort_bout",  32'(bout_o),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 0);

    applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    applyStimulus(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("diff_stable_idle", 32'(diff_o), 32'h10);
    checkOutput("sb_queue_empty", 32'(sbQueue.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
